serial_shift_unit: RTL and testbench

// - Multi-cycle shift/rotate unit on the ALU operand path. Takes an operand, amount and op with a valid/ready handshake.
// - Shifts one bit position per clock and returns the result plus the shifter carry-out to the ALU result/flag stage.
// - Same LSR result/carry semantics as the combinational right shifter.
// - Trades latency for area versus the combinational barrel shifters.

---
 rtl/serial_shift_unit_if.sv | 27 ++
 rtl/serial_shift_unit.sv | 119 +++++++++++
 tb/tb_serial_shift_unit.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/serial_shift_unit_if.sv
// Request/response bundle for the serial shift unit: operand request in, result and carry out.
interface serial_shift_unit_if #(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num;
    logic [SHW-1:0]   shifts;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] shifted;
    logic             c_out;
    logic             busy;

    modport master (
        output in_valid, num, shifts, op, out_ready,
        input  in_ready, out_valid, shifted, c_out, busy
    );

    modport slave (
        input  in_valid, num, shifts, op, out_ready,
        output in_ready, out_valid, shifted, c_out, busy
    );
endinterface

// File: rtl/serial_shift_unit.sv
// Bit-serial shift/rotate unit: one bit position per clock, LSL/LSR/ASR/ROR with carry-out.
// Define SERIAL_SHIFT_ROR_EN to enable the ROR datapath; otherwise op=11 passes the operand through.
module serial_shift_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic                clk,
    input logic                rst,
    serial_shift_unit_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic [SHW-1:0]   count;
    logic [1:0]       op_q;
    logic             ready_q;
    logic             valid_q;
    logic             busy_q;

    logic [WIDTH-1:0] step_c;
    logic             step_carry_c;
    logic             direct_c;

    assign bus.shifted   = result_q;
    assign bus.c_out     = carry_q;
    assign bus.in_ready  = ready_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = busy_q;

    // One-bit step of the held operand, with the bit moved out as carry.
    always_comb begin
        step_c       = result_q;
        step_carry_c = result_q[0];
        case (op_q)
            2'b00: begin
                step_c       = {result_q[WIDTH-2:0], 1'b0};
                step_carry_c = result_q[WIDTH-1];
            end
            2'b01: step_c = {1'b0, result_q[WIDTH-1:1]};
            2'b10: step_c = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
`ifdef SERIAL_SHIFT_ROR_EN
            2'b11: step_c = {result_q[0], result_q[WIDTH-1:1]};
`endif
            default: begin
                step_c       = result_q;
                step_carry_c = carry_q;
            end
        endcase
    end

    // Requests that need no stepping go straight to DONE.
`ifdef SERIAL_SHIFT_ROR_EN
    assign direct_c = (bus.shifts == '0);
`else
    assign direct_c = (bus.shifts == '0) || (bus.op == 2'b11);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            result_q <= '0;
            carry_q  <= 1'b0;
            count    <= '0;
            op_q     <= 2'b00;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        result_q <= bus.num;
                        count    <= bus.shifts;
                        op_q     <= bus.op;
                        carry_q  <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        if (direct_c) begin
                            state   <= DONE;
                            valid_q <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    result_q <= step_c;
                    carry_q  <= step_carry_c;
                    count    <= count - SHW'(1);
                    if (count == SHW'(1)) begin
                        state   <= DONE;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_shift_unit.sv
// Directed bench for serial_shift_unit; expectations follow SERIAL_SHIFT_ROR_EN for op=11.
module tb_serial_shift_unit;
    localparam int unsigned WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    serial_shift_unit_if #(.WIDTH(WIDTH)) bus ();

    serial_shift_unit #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, measure latency, check result, then retire it.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] n,
                          input logic [4:0] s, input logic [31:0] er, input logic ec,
                          input int elat);
        int lat;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.num      = n;
        bus.shifts   = s;
        tick();
        bus.in_valid = 1'b0;
        bus.num      = 32'h5A5A_A5A5;
        bus.shifts   = 5'd7;
        bus.op       = ~o;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_shifted"}, bus.shifted, er);
        chk({tag, "_c_out"}, 32'(bus.c_out), 32'(ec));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({tag, "_retire_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_retire_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [31:0] ror_exp;
        logic        ror_c;
        int          ror_lat;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.num       = '0;
        bus.shifts    = '0;
        bus.op        = 2'b00;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_shifted", bus.shifted, 32'h0);
        chk("reset_c_out", 32'(bus.c_out), 32'd0);

        run_op("lsr1", 2'b01, 32'h8000_0001, 5'd1, 32'h4000_0000, 1'b1, 2);
        run_op("lsr31", 2'b01, 32'hF000_0000, 5'd31, 32'h0000_0001, 1'b1, 32);
        run_op("lsl1", 2'b00, 32'hC000_0000, 5'd1, 32'h8000_0000, 1'b1, 2);
        run_op("lsl31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 32);
        run_op("asr4", 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 5);
        run_op("asr2c", 2'b10, 32'h8000_000E, 5'd2, 32'hE000_0003, 1'b1, 3);

        // Zero amount after a carry-setting op: c_out must clear on accept.
        run_op("lsl0", 2'b00, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 1);
        run_op("lsr0", 2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 1);
        run_op("asr0", 2'b10, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 1);
        run_op("ror0", 2'b11, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 1);

`ifdef SERIAL_SHIFT_ROR_EN
        ror_exp = 32'h8000_0001;
        ror_c   = 1'b1;
        ror_lat = 2;
`else
        ror_exp = 32'h0000_0003;
        ror_c   = 1'b0;
        ror_lat = 1;
`endif
        run_op("ror1", 2'b11, 32'h0000_0003, 5'd1, ror_exp, ror_c, ror_lat);

        // Hold DONE with out_ready low while a second request waits.
        bus.in_valid = 1'b1;
        bus.op       = 2'b00;
        bus.num      = 32'h0000_0001;
        bus.shifts   = 5'd2;
        tick();
        bus.op     = 2'b01;
        bus.num    = 32'h0000_0010;
        bus.shifts = 5'd1;
        chk("hs_busy_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        chk("hs_done", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hs_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hs_hold_shifted", bus.shifted, 32'h0000_0004);
            chk("hs_hold_c_out", 32'(bus.c_out), 32'd0);
            chk("hs_hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("hs_release_valid", 32'(bus.out_valid), 32'd0);
        chk("hs_release_busy", 32'(bus.busy), 32'd0);
        chk("hs_release_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("hs_second_accept", 32'(bus.busy), 32'd1);
        tick();
        chk("hs_second_valid", 32'(bus.out_valid), 32'd1);
        chk("hs_second_shifted", bus.shifted, 32'h0000_0008);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Reset during a long LSR aborts it.
        bus.in_valid = 1'b1;
        bus.op       = 2'b01;
        bus.num      = 32'hFFFF_FFFF;
        bus.shifts   = 5'd20;
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("abort_mid_busy", 32'(bus.busy), 32'd1);
        chk("abort_mid_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_shifted", bus.shifted, 32'h0);
        chk("abort_c_out", 32'(bus.c_out), 32'd0);
        for (int i = 0; i < 25; i++) tick();
        chk("abort_no_result", 32'(bus.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
